// File: rtl/j1708_tx_engine.sv
// J1708 transmit engine: buffers a message, waits for priority-dependent bus idle,
// sends bytes plus checksum as UART 8N1 and backs off on readback collisions.
module j1708_tx_engine #(
    parameter int CLK_FRQ_MHZ = 26,
    parameter int BAUD_RATE   = 9600,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] tx_message_byte,
    input  logic       tx_message_byte_valid,
    input  logic [7:0] tx_message_length,
    input  logic [2:0] tx_message_priority,
    input  logic       tx_message_new,
    input  logic       J1708_rx,
    output logic       J1708_tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int BT        = CLK_FRQ_MHZ * 1000000 / BAUD_RATE;
    localparam int BUF_DEPTH = 20;
    localparam int IDLE_MAX  = 26 * BT;
    localparam int IDLE_W    = $clog2(IDLE_MAX + 1);
    localparam int BT_W      = $clog2(BT + 1);
    localparam int RTY_W     = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [4:0]       r_wptr;
    logic [4:0]       r_byte_idx;
    logic [2:0]       r_bit_idx;
    logic [2:0]       r_prio;
    logic [7:0]       r_len;
    logic [7:0]       r_sum;
    logic [7:0]       r_shift;
    logic [RTY_W-1:0] r_retry;
    logic [IDLE_W-1:0] r_idle;
    logic [BT_W-1:0]  r_bt_cnt;
    logic [7:0]       r_buf [BUF_DEPTH];

    logic [IDLE_W-1:0] w_idle_next;
    logic [IDLE_W-1:0] w_thr;
    logic              w_bit_end;
    logic              w_sample;
    logic              w_collide;
    logic              w_last;
    logic              w_go_start;
    logic              w_next_byte;
    logic [4:0]        w_load_idx;
    logic              w_load_csum;
    logic [7:0]        w_load_byte;
    logic              w_len_bad;
    logic              w_wr;
    logic              w_load;
    logic              w_shift;
    logic              w_abort;
    logic              w_fail;
    logic              w_ok;
    logic              w_reject;
    logic              w_finish;

    function automatic logic [7:0] checksum(input logic [7:0] sum);
        return 8'd0 - sum;
    endfunction

    always_comb begin
        w_idle_next = '0;
        if (J1708_rx) begin
            w_idle_next = (r_idle == IDLE_W'(IDLE_MAX)) ? r_idle : r_idle + IDLE_W'(1);
        end
    end

    // Idle threshold is compared against the next count so the first start bit
    // lands exactly (12 + 2*prio) bit times after the bus went high.
    assign w_thr       = IDLE_W'((12 + 2 * int'(r_prio)) * BT);
    assign w_bit_end   = (r_bt_cnt == BT_W'(BT - 1));
    assign w_sample    = (r_bt_cnt == BT_W'(BT / 2));
    assign w_collide   = ((r_state == S_START) || (r_state == S_DATA)) && w_sample && (J1708_rx != r_tx);
    assign w_last      = ({3'b000, r_byte_idx} == r_len);
    assign w_go_start  = (r_state == S_WAIT_BUS) && (w_idle_next >= w_thr);
    assign w_next_byte = (r_state == S_STOP) && w_bit_end && !w_last;
    assign w_load_idx  = (r_state == S_STOP) ? r_byte_idx + 5'd1 : 5'd0;
    assign w_load_csum = ({3'b000, w_load_idx} == r_len);
    assign w_load_byte = w_load_csum ? checksum(r_sum) : r_buf[w_load_idx];
    assign w_len_bad   = (tx_message_length == 8'd0) || (tx_message_length > 8'(BUF_DEPTH))
                      || (tx_message_length > {3'b000, r_wptr});
    assign w_wr        = tx_message_byte_valid && !r_busy && (r_wptr < 5'(BUF_DEPTH));
    assign w_load      = enable && (w_go_start || w_next_byte);
    assign w_shift     = enable && w_bit_end && !w_collide
                      && ((r_state == S_START) || ((r_state == S_DATA) && (r_bit_idx != 3'd7)));

    assign w_abort  = (r_state != S_IDLE) && !enable;
    assign w_fail   = !w_abort && w_collide && (r_retry >= RTY_W'(MAX_RETRY));
    assign w_ok     = !w_abort && (r_state == S_STOP) && w_bit_end && w_last;
    assign w_reject = (r_state == S_IDLE) && tx_message_new && enable && w_len_bad;
    assign w_finish = w_abort || w_fail || w_ok || w_reject;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wptr     <= '0;
            r_retry    <= '0;
            r_idle     <= '0;
            r_bt_cnt   <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_sum      <= '0;
            r_len      <= '0;
            r_prio     <= '0;
        end else begin
            r_done <= 1'b0;
            r_idle <= w_idle_next;
            if (w_wr) begin
                r_wptr <= r_wptr + 5'd1;
            end
            // Every completion, good or bad, empties the buffer.
            if (w_finish) begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_err   <= !w_ok;
                r_wptr  <= '0;
                r_retry <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_message_new && enable) begin
                            r_len      <= tx_message_length;
                            r_prio     <= tx_message_priority;
                            r_busy     <= 1'b1;
                            r_retry    <= '0;
                            r_sum      <= '0;
                            r_byte_idx <= '0;
                            r_state    <= S_WAIT_BUS;
                        end
                    end
                    S_WAIT_BUS: begin
                        if (w_go_start) begin
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                            r_bt_cnt   <= '0;
                            r_byte_idx <= '0;
                            r_sum      <= w_load_byte;
                        end
                    end
                    S_START, S_DATA: begin
                        if (w_collide) begin
                            r_retry    <= r_retry + RTY_W'(1);
                            r_state    <= S_WAIT_BUS;
                            r_tx       <= 1'b1;
                            r_byte_idx <= '0;
                            r_sum      <= '0;
                        end else if (w_bit_end) begin
                            r_bt_cnt <= '0;
                            if (r_state == S_START) begin
                                r_state   <= S_DATA;
                                r_bit_idx <= '0;
                                r_tx      <= r_shift[0];
                            end else if (r_bit_idx == 3'd7) begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_tx      <= r_shift[0];
                            end
                        end else begin
                            r_bt_cnt <= r_bt_cnt + BT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_bit_end) begin
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                            r_bt_cnt   <= '0;
                            r_byte_idx <= w_load_idx;
                            if (!w_load_csum) begin
                                r_sum <= r_sum + w_load_byte;
                            end
                        end else begin
                            r_bt_cnt <= r_bt_cnt + BT_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_wptr] <= tx_message_byte;
        end
        if (w_load) begin
            r_shift <= w_load_byte;
        end else if (w_shift) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    assign J1708_tx = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign tx_error = r_err;

endmodule

// File: tb/tb_j1708_tx_engine.sv
// Scoreboard bench for j1708_tx_engine: a UART decoder and a completion monitor
// pop expected frames and status pushed by the directed stimulus.
module tb_j1708_tx_engine;

    localparam int BT = 10;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] msg_byte;
    logic       byte_valid;
    logic [7:0] msg_len;
    logic [2:0] msg_prio;
    logic       msg_new;
    logic       rx_line;
    logic       tx_line;
    logic       busy;
    logic       done;
    logic       err;
    logic       force_low;
    logic       mon_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       exp_done_q[$];

    j1708_tx_engine #(
        .CLK_FRQ_MHZ(1),
        .BAUD_RATE  (100000),
        .MAX_RETRY  (3)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .tx_message_byte      (msg_byte),
        .tx_message_byte_valid(byte_valid),
        .tx_message_length    (msg_len),
        .tx_message_priority  (msg_prio),
        .tx_message_new       (msg_new),
        .J1708_rx             (rx_line),
        .J1708_tx             (tx_line),
        .tx_busy              (busy),
        .tx_done              (done),
        .tx_error             (err)
    );

    assign rx_line = force_low ? 1'b0 : tx_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        msg_byte   = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic start(input logic [7:0] len, input logic [2:0] prio);
        msg_len  = len;
        msg_prio = prio;
        msg_new  = 1'b1;
        tick();
        msg_new  = 1'b0;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (tx_line !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_start_bit: timeout after %0d cycles, expected a start bit", n);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    // UART frame decoder: samples mid-bit and scores each frame
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic       tx_prev;
        tx_prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx_prev === 1'b1 && tx_line === 1'b0) begin
                repeat (BT / 2) @(posedge clk);
                #1;
                check("start_mid", tx_line, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BT) @(posedge clk);
                    #1;
                    b[i] = tx_line;
                end
                repeat (BT) @(posedge clk);
                #1;
                check("stop_bit", tx_line, 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%02h, no frame expected", b);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_byte", b, e);
                end
            end
            tx_prev = tx_line;
        end
    end

    // Completion monitor
    initial begin
        logic e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_error", err, e);
                    check("busy_at_done", busy, 1'b0);
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] sum;
        logic [7:0] v;

        rst        = 1'b1;
        enable     = 1'b1;
        msg_byte   = 8'h00;
        byte_valid = 1'b0;
        msg_len    = 8'h00;
        msg_prio   = 3'd0;
        msg_new    = 1'b0;
        force_low  = 1'b0;
        mon_en     = 1'b0;

        repeat (3) tick();
        check("rst_tx", tx_line, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // Basic message, priority 0: 12 BT gap then 0x80 0x01 0x7F
        mon_en    = 1'b1;
        force_low = 1'b1;
        write_byte(8'h80);
        write_byte(8'h01);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h7F);
        exp_done_q.push_back(1'b0);
        start(8'd2, 3'd0);
        check("busy_after_start", busy, 1'b1);
        force_low = 1'b0;
        wait_fall(n);
        check("prio0_gap", n, 12 * BT);
        wait_done();
        repeat (3) tick();
        check("err_hold_ok", err, 1'b0);
        check("done_single_pulse", done, 1'b0);

        // Priority 7 with bus held low until release
        force_low = 1'b1;
        write_byte(8'h55);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAB);
        exp_done_q.push_back(1'b0);
        start(8'd1, 3'd7);
        repeat (5) tick();
        force_low = 1'b0;
        wait_fall(n);
        check("prio7_gap", n, 26 * BT);
        wait_done();
        repeat (2) tick();

        // 22 bytes written, only 20 kept; full-length message
        force_low = 1'b1;
        sum = 8'h00;
        for (int i = 0; i < 22; i++) begin
            v = 8'(i * 7 + 3);
            write_byte(v);
            if (i < 20) begin
                exp_q.push_back(v);
                sum = sum + v;
            end
        end
        exp_q.push_back(8'h00 - sum);
        exp_done_q.push_back(1'b0);
        start(8'd20, 3'd0);
        force_low = 1'b0;
        wait_done();
        repeat (2) tick();
        mon_en = 1'b0;

        // Start ignored while disabled
        write_byte(8'h11);
        enable = 1'b0;
        start(8'd1, 3'd0);
        check("disabled_busy", busy, 1'b0);
        tick();
        check("disabled_done", done, 1'b0);
        enable = 1'b1;
        tick();

        // Length 0 rejected
        exp_done_q.push_back(1'b1);
        start(8'd0, 3'd0);
        check("len0_done", done, 1'b1);
        check("len0_err", err, 1'b1);
        check("len0_tx", tx_line, 1'b1);
        tick();

        // Length 5 with 3 bytes written rejected
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        exp_done_q.push_back(1'b1);
        start(8'd5, 3'd0);
        check("short_done", done, 1'b1);
        check("short_err", err, 1'b1);
        check("short_tx", tx_line, 1'b1);
        tick();
        check("short_pulse_end", done, 1'b0);
        check("short_err_hold", err, 1'b1);

        // Collisions on data bit 3 of 0x08; fourth one gives up
        force_low = 1'b1;
        write_byte(8'h08);
        exp_done_q.push_back(1'b1);
        start(8'd1, 3'd0);
        force_low = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            wait_fall(n);
            check("retry_gap", n, 12 * BT);
            repeat (4 * BT + 2) tick();
            force_low = 1'b1;
            repeat (4) tick();
            check("collide_tx", tx_line, 1'b1);
            if (a < 4) begin
                check("collide_busy", busy, 1'b1);
            end else begin
                check("giveup_done", done, 1'b1);
                check("giveup_err", err, 1'b1);
            end
            repeat (BT) tick();
            check("collide_tx_held", tx_line, 1'b1);
            force_low = 1'b0;
        end
        repeat (2) tick();
        check("giveup_busy", busy, 1'b0);

        // Enable dropped in second byte
        force_low = 1'b1;
        write_byte(8'h12);
        write_byte(8'h34);
        exp_done_q.push_back(1'b1);
        start(8'd2, 3'd0);
        force_low = 1'b0;
        wait_fall(n);
        repeat (10 * BT) tick();
        check("byte2_start", tx_line, 1'b0);
        repeat (2 * BT + 3) tick();
        check("byte2_bit1", tx_line, 1'b0);
        enable = 1'b0;
        tick();
        check("abort_tx", tx_line, 1'b1);
        check("abort_done", done, 1'b1);
        check("abort_err", err, 1'b1);
        enable = 1'b1;
        repeat (3) tick();

        // Reset mid-byte: no completion, outputs back to reset values
        force_low = 1'b1;
        write_byte(8'hA5);
        start(8'd1, 3'd0);
        force_low = 1'b0;
        wait_fall(n);
        repeat (2 * BT + 3) tick();
        check("pre_rst_tx", tx_line, 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_tx", tx_line, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        tick();
        rst = 1'b0;
        repeat (40 * BT) tick();
        check("post_rst_tx", tx_line, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        // Reset emptied the buffer, so length 1 is rejected
        exp_done_q.push_back(1'b1);
        start(8'd1, 3'd0);
        check("post_rst_reject", done, 1'b1);
        check("post_rst_reject_err", err, 1'b1);
        repeat (3) tick();

        check("frames_left", exp_q.size(), 0);
        check("done_left", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/j1708_tx_engine.md
J1708_TX_ENGINE -- requirements
Module: j1708_tx_engine

Interface
REQ-001 SHALL have parameter CLK_FRQ_MHZ, default 26, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, J1708 bit rate.
REQ-003 SHALL have parameter MAX_RETRY, default 3, collision retries before giving up.
REQ-004 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  J1708 transmit enable from register block.
REQ-007 tx_message_byte  input  8  message byte (MID first) to buffer.
REQ-008 tx_message_byte_valid  input  1  one-cycle write strobe for tx_message_byte.
REQ-009 tx_message_length  input  8  number of buffered bytes, checksum excluded.
REQ-010 tx_message_priority  input  3  priority 0..7 (J1708 priority 1..8).
REQ-011 tx_message_new  input  1  one-cycle start strobe.
REQ-012 J1708_rx  input  1  transceiver receive line (bus readback, idle high).
REQ-013 J1708_tx  output  1  transceiver transmit line (idle high).
REQ-014 tx_busy  output  1  high from accepted start until tx_done.
REQ-015 tx_done  output  1  one-cycle completion pulse.
REQ-016 tx_error  output  1  status valid with tx_done: 1 = aborted/failed.

Function
REQ-017 SHALL define bit time BT = CLK_FRQ_MHZ*1000000/BAUD_RATE clocks (integer; 2708 at defaults).
REQ-018 SHALL store bytes in a 20-entry buffer; each tx_message_byte_valid writes at write pointer, pointer +1, saturating at 20 (extra bytes dropped); writes ignored while tx_busy.
REQ-019 SHALL accept tx_message_new only in IDLE with enable=1; otherwise ignore it.
REQ-020 SHALL, on accepted start with length 0 or >20 or > write pointer, pulse tx_done with tx_error=1 next cycle, clear write pointer, stay IDLE.
REQ-021 SHALL otherwise latch length and priority, assert tx_busy next cycle, enter WAIT_BUS.
REQ-022 SHALL keep an idle counter of consecutive clocks with J1708_rx=1, cleared by any J1708_rx=0, running in all states.
REQ-023 WAIT_BUS: SHALL move to START when idle counter reaches (12 + 2*priority)*BT.
REQ-024 SHALL transmit each byte as UART 8N1, LSB first: START (0, 1 BT), DATA (8 x 1 BT), STOP (1, 1 BT); next byte starts immediately after STOP, no gap.
REQ-025 SHALL append checksum byte = two's complement of 8-bit sum of all message bytes, sent after the last buffered byte.
REQ-026 SHALL sample J1708_rx at BT/2 of every start and data bit; mismatch against driven value is a collision.
REQ-027 On collision SHALL drive J1708_tx=1 same cycle as detection, increment retry count, restart at byte 0 in WAIT_BUS.
REQ-028 When retry count exceeds MAX_RETRY SHALL pulse tx_done with tx_error=1 and return IDLE.
REQ-029 After checksum STOP bit SHALL pulse tx_done with tx_error=0, deassert tx_busy same cycle, clear write pointer and retry count, return IDLE.
REQ-030 enable falling while busy SHALL abort within 1 cycle: J1708_tx=1, tx_done pulse with tx_error=1, IDLE.
REQ-031 J1708_tx SHALL be driven from a register (glitch-free), high in all states except START/DATA zeros.
REQ-032 tx_error SHALL hold its value until next tx_done.

Reset
REQ-033 rst SHALL force: state IDLE, J1708_tx=1, tx_busy=0, tx_done=0, tx_error=0, write pointer, retry and idle counters 0.
REQ-034 rst mid-transmission SHALL take effect next edge; the byte in flight is truncated, no tx_done pulse.

Verification
REQ-035 Write 0x80,0x01, length 2, prio 0, rx looped to tx -> after 12 BT idle: frames 0x80,0x01,0x7F; tx_done=1, tx_error=0.
REQ-036 Priority 7 with bus held low until t0 -> first start bit exactly 26*BT clocks after t0.
REQ-037 Force J1708_rx=0 during data bit 3 of first byte (driven 1) -> J1708_tx high next cycle, retry from byte 0; 4 forced collisions -> tx_done with tx_error=1.
REQ-038 Length 0, and length 5 with 3 bytes written -> tx_done, tx_error=1 one cycle after strobe, J1708_tx stays 1.
REQ-039 Deassert enable in 2nd byte -> J1708_tx=1 within 1 cycle, tx_done with tx_error=1; then rst mid-message -> all outputs at reset values, no tx_done.
